// File: rtl/rans_dec_if.sv
// Byte and symbol streams of the rANS decoder, both valid/ready.
// The decoder is the slave: it sinks renorm bytes and sources decoded symbols.
interface rans_dec_if #(
   parameter int SYMBOL_WIDTH = 8
);
   logic                    byte_valid;
   logic [SYMBOL_WIDTH-1:0] byte_dat;
   logic                    byte_ready;
   logic                    sym_valid;
   logic [SYMBOL_WIDTH-1:0] sym_dat;
   logic                    sym_ready;

   modport master (
      output byte_valid, byte_dat, sym_ready,
      input  byte_ready, sym_valid, sym_dat
   );

   modport slave (
      input  byte_valid, byte_dat, sym_ready,
      output byte_ready, sym_valid, sym_dat
   );
endinterface

// File: rtl/rans_dec.sv
// rANS decoder: rebuilds the symbol sequence from the final encoder state and its renorm bytes (LIFO).
// Five cycles per symbol plus one per consumed byte; stalls in RENORM on byte_valid and in OUT on sym_ready.
module rans_dec #(
   parameter  int RESOLUTION   = 10,
   parameter  int SYMBOL_WIDTH = 8,
   parameter  int COUNT_WIDTH  = 16,
   localparam int STATE_WIDTH  = RESOLUTION + SYMBOL_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    freq_wr_i,
   input  logic [SYMBOL_WIDTH-1:0] freq_addr_i,
   input  logic [RESOLUTION-1:0]   freq_i,
   input  logic [RESOLUTION-1:0]   cum_freq_i,
   input  logic                    slot_wr_i,
   input  logic [RESOLUTION-1:0]   slot_addr_i,
   input  logic [SYMBOL_WIDTH-1:0] slot_symb_i,
   input  logic                    start_i,
   input  logic [STATE_WIDTH-1:0]  init_state_i,
   input  logic [COUNT_WIDTH-1:0]  count_i,
   rans_dec_if.slave               strm,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam logic [STATE_WIDTH-1:0] L_MIN = STATE_WIDTH'(1) << RESOLUTION;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      FETCH,
      CALC,
      RENORM,
      OUT
   } state_e;

   typedef struct packed {
      logic [RESOLUTION-1:0] freq;
      logic [RESOLUTION-1:0] cum;
   } freq_ent_t;

   freq_ent_t               freq_tab [2**SYMBOL_WIDTH];
   logic [SYMBOL_WIDTH-1:0] slot_tab [2**RESOLUTION];

   state_e                  state_q, state_d;
   logic [STATE_WIDTH-1:0]  x_q, x_d;
   logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;
   logic [RESOLUTION-1:0]   f_q, f_d;
   logic [RESOLUTION-1:0]   c_q, c_d;
   logic                    done_q, done_d;

   freq_ent_t               freq_rd;
   logic [SYMBOL_WIDTH-1:0] slot_rd;
   logic [STATE_WIDTH-1:0]  x_calc;

   // Tables are host state: never reset, frozen while a decode runs.
   always_ff @(posedge clk_i) begin
      if (!busy_o && freq_wr_i) begin
         freq_tab[freq_addr_i] <= '{freq: freq_i, cum: cum_freq_i};
      end
      if (!busy_o && slot_wr_i) begin
         slot_tab[slot_addr_i] <= slot_symb_i;
      end
   end

   assign slot_rd = slot_tab[x_q[RESOLUTION-1:0]];
   assign freq_rd = freq_tab[sym_q];

   // x is untouched between LOOKUP and CALC, so its low bits still hold the slot here.
   assign x_calc = STATE_WIDTH'(f_q) * (x_q >> RESOLUTION)
                 + STATE_WIDTH'(x_q[RESOLUTION-1:0])
                 - STATE_WIDTH'(c_q);

   always_comb begin
      state_d         = state_q;
      x_d             = x_q;
      cnt_d           = cnt_q;
      sym_d           = sym_q;
      f_d             = f_q;
      c_d             = c_q;
      done_d          = 1'b0;
      strm.byte_ready = 1'b0;
      strm.sym_valid  = 1'b0;
      strm.sym_dat    = '0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (count_i != '0) begin
                  x_d     = init_state_i;
                  cnt_d   = count_i;
                  state_d = LOOKUP;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         LOOKUP: begin
            sym_d   = slot_rd;
            state_d = FETCH;
         end
         FETCH: begin
            f_d     = freq_rd.freq;
            c_d     = freq_rd.cum;
            state_d = CALC;
         end
         CALC: begin
            x_d     = x_calc;
            state_d = RENORM;
         end
         RENORM: begin
            if (x_q < L_MIN) begin
               strm.byte_ready = 1'b1;
               if (strm.byte_valid) begin
                  x_d = {x_q[STATE_WIDTH-SYMBOL_WIDTH-1:0], strm.byte_dat};
               end
            end else begin
               state_d = OUT;
            end
         end
         OUT: begin
            strm.sym_valid = 1'b1;
            strm.sym_dat   = sym_q;
            if (strm.sym_ready) begin
               cnt_d = cnt_q - COUNT_WIDTH'(1);
               if (cnt_q == COUNT_WIDTH'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = LOOKUP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         x_q     <= L_MIN;
         cnt_q   <= '0;
         sym_q   <= '0;
         f_q     <= '0;
         c_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         sym_q   <= sym_d;
         f_q     <= f_d;
         c_q     <= c_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = done_q;

endmodule
